adder_accumulator: RTL and testbench
====================================

# adder_accumulator

Multi-operand accumulator that sits directly downstream of the 4-bit ripple-carry adder datapath. It consumes a stream of WIDTH-bit operands over a valid/ready handshake and sums exactly N_TERMS of them into a registered ACC_WIDTH-bit result. It presents that result with a sticky overflow flag over a second valid/ready handshake. Typical use: summing a burst of adder outputs (Sum plus Cout as a 5-bit value) before handing the total to a consumer.

## Interface
- WIDTH, 4, operand width in bits; must be ≥ 1.
- ACC_WIDTH, 8, accumulator and result width; must be ≥ WIDTH + 1.
- N_TERMS, 4, operands summed per transaction; must be ≥ 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a transaction; sampled only in IDLE.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts an operand this cycle.
- in_data  input  WIDTH  unsigned operand, zero-extended to ACC_WIDTH.
- out_valid  output  1  sum and overflow are valid.
- out_ready  input  1  consumer takes the result this cycle.
- sum  output  ACC_WIDTH  accumulated total, modulo 2^ACC_WIDTH.
- overflow  output  1  sticky; set if any addition in this transaction carried out of bit ACC_WIDTH-1.
- busy  output  1  high in ACCUM and DONE.

## Operation
- State machine with states IDLE, ACCUM and DONE.
- **IDLE**
  - Outputs: in_ready=0, out_valid=0, busy=0.
  - start=1 clears acc, count and overflow, and moves to ACCUM on the next edge.
  - in_valid and out_ready are ignored.
- **ACCUM**
  - Outputs: in_ready=1, out_valid=0, busy=1.
  - Accept occurs when in_valid && in_ready. On an accept:
    - acc <= acc + zero-extended in_data, modulo 2^ACC_WIDTH.
    - overflow <= overflow | carry-out of the ACC_WIDTH-bit add.
    - count <= count + 1.
  - A cycle with no accept holds all state; bubbles are allowed indefinitely.
  - The accept that makes count equal N_TERMS moves to DONE on the same edge.
  - start is ignored.
- **DONE**
  - Outputs: in_ready=0, out_valid=1, busy=1.
  - sum and overflow are stable for as long as out_valid=1.
  - out_valid && out_ready moves to IDLE on the next edge.
  - start is ignored, including when it coincides with the out_ready handshake. A new transaction needs start asserted while in IDLE.
- **Output rules**
  - sum always reflects the acc register.
  - After a transaction, sum and overflow hold their last values through IDLE until the next start clears them.
- **Internal widths**
  - count is $clog2(N_TERMS+1) bits.
  - The adder is ACC_WIDTH+1 bits wide internally to capture the carry.

## Timing
- **Reset** (asynchronous, takes effect immediately, regardless of state):
  - state=IDLE; acc=0, sum=0, count=0, overflow=0.
  - in_ready=0, out_valid=0, busy=0.
- **Reset mid-transaction:** the partial sum is discarded and no result is produced.
- in_ready, out_valid and busy are decoded from the registered state only. There is no combinational path from any input to any output.
- **Latency**
  - start to first possible accept: 1 cycle (start at edge t, in_ready=1 from t+1).
  - Last accept to out_valid=1: 1 cycle.
  - out_ready handshake to IDLE: 1 cycle.
- **Minimum transaction length:** N_TERMS + 2 cycles (start, N accepts, one DONE cycle with out_ready=1).
- **Back-pressure:** out_valid stays high with a stable result for any number of cycles with out_ready=0.

## Test plan
- Defaults; start, then operands 1, 2, 3, 4 back-to-back -> out_valid exactly 1 cycle after the 4th accept, sum=8'd10, overflow=0, busy falls 1 cycle after the out_ready handshake.
- Defaults; operands 15, 15, 15, 15 with in_valid low for 2 cycles between each -> in_ready stays 1 throughout ACCUM, only 4 accepts occur, sum=8'd60, overflow=0.
- ACC_WIDTH=5; operands 15, 15, 15, 15 (total 60) -> sum=5'd28, overflow=1. A following transaction of 1, 1, 1, 1 -> sum=4, overflow=0, which confirms the clear on start.
- Defaults; result 10 with out_ready held 0 for 5 cycles, then 1 -> out_valid and sum=10 stable for all 6 cycles, then IDLE. in_valid held 1 during DONE is not accepted.
- Defaults; start, accept 7 and 9, then assert rst mid-cycle -> outputs go immediately to reset values. A new start with 1, 1, 1, 1 -> sum=4.
- Defaults; start pulsed again during ACCUM and together with the DONE handshake -> no effect: the sum is unchanged, and the block stays in IDLE until a fresh start.

Source files
------------

// File: rtl/adder_accumulator.sv
// Streams N_TERMS unsigned operands through a valid/ready handshake into a
// registered ACC_WIDTH-bit sum, then offers the result with a sticky carry-out flag.
module adder_accumulator #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int N_TERMS   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 overflow,
  output logic                 busy
);

  localparam int CW = $clog2(N_TERMS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CW-1:0]        r_count;
  logic                 r_ovf;

  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH:0]   w_add;
  logic                 w_accept;
  logic                 w_last;

  // One spare bit on the adder catches the carry out of the accumulator.
  assign w_ext    = {{(ACC_WIDTH-WIDTH){1'b0}}, in_data};
  assign w_add    = {1'b0, r_acc} + {1'b0, w_ext};
  assign w_accept = (r_state == S_ACCUM) && in_valid;
  assign w_last   = (r_count == CW'(N_TERMS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_add[ACC_WIDTH-1:0];
            r_ovf   <= r_ovf | w_add[ACC_WIDTH];
            r_count <= r_count + CW'(1);
            if (w_last) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs depend on registered state only.
  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign sum       = r_acc;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_adder_accumulator.sv
// Drives two accumulators (8-bit and 5-bit result) with the same directed
// transactions; a monitor checks each presented result against a scoreboard.
module tb_adder_accumulator;

  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;
  logic [3:0] in_data;
  logic in_ready_a, out_valid_a, ovf_a, busy_a;
  logic in_ready_b, out_valid_b, ovf_b, busy_b;
  logic [7:0] sum_a;
  logic [4:0] sum_b;

  int checks = 0;
  int errors = 0;

  logic [8:0] qa[$];
  logic [5:0] qb[$];

  always #5 clk = ~clk;

  adder_accumulator #(.WIDTH(4), .ACC_WIDTH(8), .N_TERMS(4)) u_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready), .sum(sum_a),
    .overflow(ovf_a), .busy(busy_a));

  adder_accumulator #(.WIDTH(4), .ACC_WIDTH(5), .N_TERMS(4)) u_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready), .sum(sum_b),
    .overflow(ovf_b), .busy(busy_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: result must match queue head on every valid cycle.
  always @(negedge clk) begin
    if (!rst && out_valid_a) begin
      if (qa.size() == 0) chk("a_unexpected_result", 1, 0);
      else begin
        chk("a_result", {23'd0, ovf_a, sum_a}, {23'd0, qa[0]});
        if (out_ready) void'(qa.pop_front());
      end
    end
    if (!rst && out_valid_b) begin
      if (qb.size() == 0) chk("b_unexpected_result", 1, 0);
      else begin
        chk("b_result", {26'd0, ovf_b, sum_b}, {26'd0, qb[0]});
        if (out_ready) void'(qb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input logic ir, input logic ov, input logic bz);
    chk({name, "_a"}, {29'd0, in_ready_a, out_valid_a, busy_a}, {29'd0, ir, ov, bz});
    chk({name, "_b"}, {29'd0, in_ready_b, out_valid_b, busy_b}, {29'd0, ir, ov, bz});
  endtask

  // ops packed op0 in low nibble; gap = idle cycles between operands;
  // hold = DONE cycles with out_ready low; glitch = stray start pulses.
  task automatic run_txn(input logic [15:0] ops, input int gap, input int hold,
                         input bit glitch, input logic [8:0] exp_a, input logic [5:0] exp_b);
    qa.push_back(exp_a);
    qb.push_back(exp_b);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_state("accum_entry", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = ops[4*i +: 4];
      start    = glitch && (i == 1);
      step();
      in_valid = 1'b0;
      start    = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          chk_state("accum_gap", 1'b1, 1'b0, 1'b1);
          step();
        end
      end
    end
    chk_state("done_latency", 1'b0, 1'b1, 1'b1);
    in_valid = (hold > 0);
    in_data  = 4'hF;
    for (int h = 0; h < hold; h++) begin
      step();
      chk_state("backpressure", 1'b0, 1'b1, 1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start     = glitch;
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    chk_state("idle_after_handshake", 1'b0, 1'b0, 1'b0);
    chk("hold_sum_a", {23'd0, ovf_a, sum_a}, {23'd0, exp_a});
    chk("hold_sum_b", {26'd0, ovf_b, sum_b}, {26'd0, exp_b});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    chk_state("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_sum_a", {23'd0, ovf_a, sum_a}, 32'd0);
    chk("reset_sum_b", {26'd0, ovf_b, sum_b}, 32'd0);
    step();
    rst = 1'b0;
    // In IDLE, in_valid/out_ready alone do nothing.
    in_valid = 1'b1; out_ready = 1'b1;
    step(); step();
    chk_state("idle_ignore", 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;

    // 1+2+3+4 back-to-back
    run_txn(16'h4321, 0, 0, 1'b0, {1'b0, 8'd10}, {1'b0, 5'd10});
    // 15 x4 with two-cycle bubbles; 60 wraps the 5-bit accumulator to 28
    run_txn(16'hFFFF, 2, 0, 1'b0, {1'b0, 8'd60}, {1'b1, 5'd28});
    // Overflow must be cleared by the next start
    run_txn(16'h1111, 0, 0, 1'b0, {1'b0, 8'd4}, {1'b0, 5'd4});
    // Back-pressure for 5 cycles with in_valid held high in DONE
    run_txn(16'h4321, 0, 5, 1'b0, {1'b0, 8'd10}, {1'b0, 5'd10});

    // Reset mid-transaction discards the partial sum
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1; in_data = 4'd7; step();
    in_data = 4'd9; step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_state("midreset", 1'b0, 1'b0, 1'b0);
    chk("midreset_sum_a", {23'd0, ovf_a, sum_a}, 32'd0);
    chk("midreset_sum_b", {26'd0, ovf_b, sum_b}, 32'd0);
    step();
    rst = 1'b0;
    step();
    run_txn(16'h1111, 0, 0, 1'b0, {1'b0, 8'd4}, {1'b0, 5'd4});

    // Stray start pulses during ACCUM and with the DONE handshake
    run_txn(16'h2222, 0, 0, 1'b1, {1'b0, 8'd8}, {1'b0, 5'd8});
    for (int k = 0; k < 3; k++) begin
      step();
      chk_state("stay_idle", 1'b0, 1'b0, 1'b0);
    end
    chk("stay_idle_sum_a", {24'd0, sum_a}, 32'd8);
    run_txn(16'h3333, 1, 1, 1'b0, {1'b0, 8'd12}, {1'b0, 5'd12});

    step();
    chk("scoreboard_drained", qa.size() + qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
